// File: rtl/rf_multiport.sv
// Multi-port integer register file with pending-write scoreboard; optional RF_BYPASS_EN same-cycle write-to-read forwarding.
// Latency: read and write responses registered, 1 cycle after the request; pending_o is registered state.
// Backpressure: none, every port accepts a request every cycle.
`timescale 1ns/1ps

package rv32i;
    typedef logic [4:0] reg_addr_t;
endpackage

package core;
    typedef struct packed {
        logic              en;
        rv32i::reg_addr_t  addr;
    } rf_read_req_t;

    typedef struct packed {
        logic        done;
        logic        valid;
        logic [31:0] value;
    } rf_read_rsp_t;

    typedef struct packed {
        logic              en;
        rv32i::reg_addr_t  addr;
        logic [31:0]       data;
    } rf_write_req_t;

    typedef struct packed {
        logic done;
        logic valid;
    } rf_write_rsp_t;
endpackage

module rf_multiport #(
    parameter int READ_PORTS  = 2,   // >= 1
    parameter int WRITE_PORTS = 1,   // >= 1
    parameter int REG_COUNT   = 32   // 16 (RV32E) or 32 (RV32I)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  core::rf_read_req_t  [READ_PORTS-1:0]  rd_req_i,
    output core::rf_read_rsp_t  [READ_PORTS-1:0]  rd_rsp_o,
    input  core::rf_write_req_t [WRITE_PORTS-1:0] wr_req_i,
    output core::rf_write_rsp_t [WRITE_PORTS-1:0] wr_rsp_o,
    input  logic                                 claim_en_i,
    input  rv32i::reg_addr_t                     claim_addr_i,
    output logic [REG_COUNT-1:0]                 pending_o
);

    // Index width matches the implemented array exactly (4 bits for RV32E).
    localparam int IW = (REG_COUNT == 16) ? 4 : 5;

    logic [31:0]          regs     [REG_COUNT];
    logic [31:0]          regs_nxt [REG_COUNT];
    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_nxt;

    core::rf_read_rsp_t  [READ_PORTS-1:0]  rd_rsp_nxt;
    core::rf_write_rsp_t [WRITE_PORTS-1:0] wr_rsp_nxt;

    // Only RV32E has unimplemented addresses (x16..x31).
    function automatic logic in_range(input rv32i::reg_addr_t a);
        return (REG_COUNT == 32) || (a[4] == 1'b0);
    endfunction

    // x0 is hardwired: never stored, never pending.
    function automatic logic writable(input rv32i::reg_addr_t a);
        return in_range(a) && (a != 5'd0);
    endfunction

    assign pending_o = pending;

    // Next array/scoreboard: writes in port order so the highest index wins, then the claim overrides the clear.
    always_comb begin
        regs_nxt    = regs;
        pending_nxt = pending;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_req_i[w].en && writable(wr_req_i[w].addr)) begin
                regs_nxt[wr_req_i[w].addr[IW-1:0]]    = wr_req_i[w].data;
                pending_nxt[wr_req_i[w].addr[IW-1:0]] = 1'b0;
            end
        end
        if (claim_en_i && writable(claim_addr_i)) begin
            pending_nxt[claim_addr_i[IW-1:0]] = 1'b1;
        end
    end

    // Write responses: acknowledge every request, valid only for implemented registers.
    always_comb begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
            wr_rsp_nxt[w] = '0;
            if (wr_req_i[w].en) begin
                wr_rsp_nxt[w].done  = 1'b1;
                wr_rsp_nxt[w].valid = in_range(wr_req_i[w].addr);
            end
        end
    end

    // Read responses: pre-write view by default, post-write view when forwarding is built in.
    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_rsp_nxt[r] = '0;
            if (rd_req_i[r].en) begin
                rd_rsp_nxt[r].done = 1'b1;
                if (in_range(rd_req_i[r].addr)) begin
`ifdef RF_BYPASS_EN
                    rd_rsp_nxt[r].value = regs_nxt[rd_req_i[r].addr[IW-1:0]];
                    rd_rsp_nxt[r].valid = !pending_nxt[rd_req_i[r].addr[IW-1:0]];
`else
                    rd_rsp_nxt[r].value = regs[rd_req_i[r].addr[IW-1:0]];
                    rd_rsp_nxt[r].valid = !pending[rd_req_i[r].addr[IW-1:0]];
`endif
                end
            end
        end
    end

    // State and response registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            pending  <= '0;
            rd_rsp_o <= '0;
            wr_rsp_o <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= regs_nxt[i];
            end
            pending  <= pending_nxt;
            rd_rsp_o <= rd_rsp_nxt;
            wr_rsp_o <= wr_rsp_nxt;
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: RV32I instance (2R/2W) plus RV32E instance (1R/1W).
// Inputs driven on the falling edge, responses sampled on the following falling edge.
// Expected read value for the same-cycle write/read case depends on RF_BYPASS_EN.
`timescale 1ns/1ps

module tb_rf_multiport;

    logic clk = 1'b0;
    logic rst_n;

    core::rf_read_req_t  [1:0] rd_req;
    core::rf_read_rsp_t  [1:0] rd_rsp;
    core::rf_write_req_t [1:0] wr_req;
    core::rf_write_rsp_t [1:0] wr_rsp;
    logic                      claim_en;
    rv32i::reg_addr_t          claim_addr;
    logic [31:0]               pending;

    core::rf_read_req_t  [0:0] rd_req2;
    core::rf_read_rsp_t  [0:0] rd_rsp2;
    core::rf_write_req_t [0:0] wr_req2;
    core::rf_write_rsp_t [0:0] wr_rsp2;
    logic                      claim_en2;
    rv32i::reg_addr_t          claim_addr2;
    logic [15:0]               pending2;

    int errors = 0;
    int checks = 0;

`ifdef RF_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h0000_000B;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_000A;
`endif

    always #5 clk = ~clk;

    rf_multiport #(.READ_PORTS(2), .WRITE_PORTS(2), .REG_COUNT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req), .rd_rsp_o(rd_rsp),
        .wr_req_i(wr_req), .wr_rsp_o(wr_rsp),
        .claim_en_i(claim_en), .claim_addr_i(claim_addr),
        .pending_o(pending)
    );

    rf_multiport #(.READ_PORTS(1), .WRITE_PORTS(1), .REG_COUNT(16)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req2), .rd_rsp_o(rd_rsp2),
        .wr_req_i(wr_req2), .wr_rsp_o(wr_rsp2),
        .claim_en_i(claim_en2), .claim_addr_i(claim_addr2),
        .pending_o(pending2)
    );

    task automatic idle();
        rd_req      = '0;
        wr_req      = '0;
        claim_en    = 1'b0;
        claim_addr  = '0;
        rd_req2     = '0;
        wr_req2     = '0;
        claim_en2   = 1'b0;
        claim_addr2 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        checks++; if (rd_rsp !== '0) begin errors++; $display("FAIL reset_rd_rsp: got %h want 0", rd_rsp); end
        checks++; if (wr_rsp !== '0) begin errors++; $display("FAIL reset_wr_rsp: got %h want 0", wr_rsp); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        checks++; if (pending2 !== '0) begin errors++; $display("FAIL reset_pending_e: got %h want 0", pending2); end
        rst_n = 1'b1;
        rd_req[0] = {1'b1, 5'd5};
        @(negedge clk);
        checks++; if (rd_rsp[0] !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL reset_read_x5: got %h want %h", rd_rsp[0], {1'b1, 1'b1, 32'h0}); end
        idle();
    endtask

    task automatic test_read_write();
        wr_req[0] = {1'b1, 5'd5, 32'hDEAD_BEEF};
        wr_req[1] = {1'b1, 5'd0, 32'h0000_1234};
        @(negedge clk);
        checks++; if (wr_rsp !== 4'b1111) begin errors++; $display("FAIL wr_rsp_x5_x0: got %b want 1111", wr_rsp); end
        idle();
        rd_req[0] = {1'b1, 5'd5};
        rd_req[1] = {1'b1, 5'd0};
        @(negedge clk);
        checks++; if (rd_rsp[0] !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL read_x5: got %h want %h", rd_rsp[0], {1'b1, 1'b1, 32'hDEAD_BEEF}); end
        checks++; if (rd_rsp[1] !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL read_x0: got %h want %h", rd_rsp[1], {1'b1, 1'b1, 32'h0}); end
        idle();
        @(negedge clk);
        checks++; if (rd_rsp !== '0) begin errors++; $display("FAIL read_disabled: got %h want 0", rd_rsp); end
    endtask

    task automatic test_collision();
        wr_req[0] = {1'b1, 5'd7, 32'h0000_0011};
        wr_req[1] = {1'b1, 5'd7, 32'h0000_0022};
        @(negedge clk);
        checks++; if (wr_rsp !== 4'b1111) begin errors++; $display("FAIL collision_wr_rsp: got %b want 1111", wr_rsp); end
        idle();
        rd_req[1] = {1'b1, 5'd7};
        @(negedge clk);
        checks++; if (rd_rsp[1] !== {1'b1, 1'b1, 32'h22}) begin errors++; $display("FAIL collision_read_x7: got %h want %h", rd_rsp[1], {1'b1, 1'b1, 32'h22}); end
        idle();
    endtask

    task automatic test_scoreboard();
        claim_en   = 1'b1;
        claim_addr = 5'd3;
        @(negedge clk);
        checks++; if (pending !== 32'h0000_0008) begin errors++; $display("FAIL claim_pending: got %h want 00000008", pending); end
        idle();
        rd_req[0] = {1'b1, 5'd3};
        @(negedge clk);
        checks++; if (rd_rsp[0] !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL read_pending_x3: got %h want %h", rd_rsp[0], {1'b1, 1'b0, 32'h0}); end
        idle();
        wr_req[0] = {1'b1, 5'd3, 32'h0000_0055};
        @(negedge clk);
        checks++; if (pending !== '0) begin errors++; $display("FAIL write_clears_pending: got %h want 0", pending); end
        idle();
        rd_req[0] = {1'b1, 5'd3};
        @(negedge clk);
        checks++; if (rd_rsp[0] !== {1'b1, 1'b1, 32'h55}) begin errors++; $display("FAIL read_x3_after_write: got %h want %h", rd_rsp[0], {1'b1, 1'b1, 32'h55}); end
        idle();
        claim_en   = 1'b1;
        claim_addr = 5'd3;
        wr_req[1]  = {1'b1, 5'd3, 32'h0000_0066};
        @(negedge clk);
        checks++; if (pending !== 32'h0000_0008) begin errors++; $display("FAIL claim_and_write: got %h want 00000008", pending); end
        idle();
        claim_en   = 1'b1;
        claim_addr = 5'd0;
        @(negedge clk);
        checks++; if (pending !== 32'h0000_0008) begin errors++; $display("FAIL claim_x0_ignored: got %h want 00000008", pending); end
        idle();
        wr_req[0] = {1'b1, 5'd3, 32'h0000_0066};
        @(negedge clk);
        checks++; if (pending !== '0) begin errors++; $display("FAIL pending_released: got %h want 0", pending); end
        idle();
    endtask

    task automatic test_bypass();
        wr_req[0] = {1'b1, 5'd9, 32'h0000_000A};
        @(negedge clk);
        idle();
        wr_req[1] = {1'b1, 5'd9, 32'h0000_000B};
        rd_req[0] = {1'b1, 5'd9};
        @(negedge clk);
        checks++; if (rd_rsp[0] !== {1'b1, 1'b1, BYP_EXP}) begin errors++; $display("FAIL same_cycle_read_x9: got %h want %h", rd_rsp[0], {1'b1, 1'b1, BYP_EXP}); end
        idle();
        rd_req[0] = {1'b1, 5'd9};
        @(negedge clk);
        checks++; if (rd_rsp[0] !== {1'b1, 1'b1, 32'hB}) begin errors++; $display("FAIL later_read_x9: got %h want %h", rd_rsp[0], {1'b1, 1'b1, 32'hB}); end
        idle();
    endtask

    task automatic test_rv32e();
        wr_req2[0] = {1'b1, 5'd4, 32'h0000_0044};
        @(negedge clk);
        checks++; if (wr_rsp2 !== 2'b11) begin errors++; $display("FAIL e_wr_rsp_x4: got %b want 11", wr_rsp2); end
        idle();
        rd_req2[0] = {1'b1, 5'd20};
        @(negedge clk);
        checks++; if (rd_rsp2[0] !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL e_read_x20: got %h want %h", rd_rsp2[0], {1'b1, 1'b0, 32'h0}); end
        idle();
        wr_req2[0]  = {1'b1, 5'd20, 32'h0000_FFFF};
        claim_en2   = 1'b1;
        claim_addr2 = 5'd20;
        @(negedge clk);
        checks++; if (wr_rsp2 !== 2'b10) begin errors++; $display("FAIL e_wr_rsp_x20: got %b want 10", wr_rsp2); end
        checks++; if (pending2 !== '0) begin errors++; $display("FAIL e_claim_x20: got %h want 0", pending2); end
        idle();
        rd_req2[0] = {1'b1, 5'd4};
        @(negedge clk);
        checks++; if (rd_rsp2[0] !== {1'b1, 1'b1, 32'h44}) begin errors++; $display("FAIL e_read_x4: got %h want %h", rd_rsp2[0], {1'b1, 1'b1, 32'h44}); end
        idle();
    endtask

    task automatic test_mid_reset();
        wr_req[0]  = {1'b1, 5'd5, 32'h0000_0077};
        rd_req[0]  = {1'b1, 5'd5};
        claim_en   = 1'b1;
        claim_addr = 5'd6;
        @(negedge clk);
        checks++; if (pending !== 32'h0000_0040) begin errors++; $display("FAIL pre_reset_pending: got %h want 00000040", pending); end
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        checks++; if (rd_rsp !== '0) begin errors++; $display("FAIL mid_reset_rd_rsp: got %h want 0", rd_rsp); end
        checks++; if (wr_rsp !== '0) begin errors++; $display("FAIL mid_reset_wr_rsp: got %h want 0", wr_rsp); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL mid_reset_pending: got %h want 0", pending); end
        idle();
        rd_req[0] = {1'b1, 5'd5};
        @(negedge clk);
        checks++; if (rd_rsp[0] !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL post_reset_read_x5: got %h want %h", rd_rsp[0], {1'b1, 1'b1, 32'h0}); end
        idle();
    endtask

    initial begin
        test_reset();
        test_read_write();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_rv32e();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-port integer register file with a pending-write scoreboard and registered read/write responses using the core `rf_*_req_t` / `rf_*_rsp_t` handshake types. It sits between the read stage (reads and claims) and the writeback stage (writes) of the core pipeline. It generalises the single-port register file to N read ports, M write ports and a configurable register count (RV32I 32 regs or RV32E 16 regs). Optional same-cycle write-to-read bypass is controlled by the `RF_BYPASS_EN` macro.

## Interface
- `READ_PORTS`, default 2: number of read ports; must be ≥1.
- `WRITE_PORTS`, default 1: number of write ports; must be ≥1.
- `REG_COUNT`, default 32: implemented registers; must be 16 or 32.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rd_req_i`, input, READ_PORTS × `core::rf_read_req_t`: read requests.
- `rd_rsp_o`, output, READ_PORTS × `core::rf_read_rsp_t`: read responses.
- `wr_req_i`, input, WRITE_PORTS × `core::rf_write_req_t`: write requests.
- `wr_rsp_o`, output, WRITE_PORTS × `core::rf_write_rsp_t`: write responses.
- `claim_en_i`, input, 1: marks `claim_addr_i` as having an in-flight producer.
- `claim_addr_i`, input, `rv32i::reg_addr_t`: destination register being claimed.
- `pending_o`, output, REG_COUNT: current scoreboard, one bit per register.

## Operation
- Storage: REG_COUNT × 32-bit array. Register 0 always reads 0 and is never pending; writes and claims to it are discarded.
- Out of range: an address ≥ REG_COUNT (RV32E only) on any request gives `done`=1, `valid`=0, `value`=0. Such a write does not modify state.
- Read: a request with `en`=1 in cycle N gives a response in cycle N+1 with `done`=1.
  - `value` = array content sampled at the end of cycle N.
  - `valid` = !pending(addr) at the end of cycle N.
  - With `en`=0, the response is all-zero in N+1.
- Write: a request with `en`=1 in cycle N updates the array at the end of cycle N. The response in N+1 is `done`=1, `valid`=1 if the address is in range.
- Write collision: several write ports targeting the same address in one cycle → the highest port index wins. All colliding ports still get `done`=1 and `valid`=1.
- Scoreboard: a claim sets `pending[addr]`. Any in-range write clears `pending[addr]`.
  - Claim and write to the same register in the same cycle → pending stays set (the claim represents the newer producer).
- `pending_o` is the registered scoreboard, with no combinational path from inputs.

## Timing
- Read latency: 1 cycle. Write latency: 1 cycle. Requests are accepted every cycle on every port with no backpressure.
- Read of an address written in the same cycle:
  - Without bypass: returns the old value.
  - With bypass: see Configuration.
- Reset (asynchronous, any time, including mid-operation):
  - Array cleared to 0.
  - `pending_o` = 0.
  - All `rd_rsp_o` and `wr_rsp_o` = 0.
  - Requests in flight are dropped. The first responses after deassertion come from requests in the first active cycle.
- Outputs change only on the rising edge of `clk` or on assertion of `rst_n`.

## Configuration
- `RF_BYPASS_EN` defined:
  - A read in cycle N to an address written in cycle N returns the written data (highest write port on collision).
  - Its `valid` reflects the post-write scoreboard, i.e. 1 unless the same register is also claimed that cycle.
- `RF_BYPASS_EN` undefined:
  - The read returns the pre-write value.
  - `valid` reflects the pre-write scoreboard.
  - No bypass mux is synthesised.

## Test plan
- Reset then read: write x5=0xDEADBEEF; read x5 next cycle → `value`=0xDEADBEEF, `valid`=1, `done`=1. Read x0 after a write of 0x1234 to x0 → `value`=0.
- Write collision: ports 0 and 1 both write x7 (0x11, 0x22) in one cycle; read x7 next cycle → 0x22; both write responses `done`=1, `valid`=1.
- Scoreboard:
  - Claim x3 in cycle N; read x3 in N+1 → `valid`=0 and `pending_o[3]`=1.
  - Write x3=0x55 in N+2; read in N+3 → `valid`=1, `value`=0x55.
  - Claim and write x3 in the same cycle → `pending_o[3]` stays 1.
- Bypass: x9=0xA, then write x9=0xB and read x9 in the same cycle → response 0xB with `RF_BYPASS_EN` defined, 0xA without it.
- RV32E (REG_COUNT=16): read x20 → `done`=1, `valid`=0, `value`=0. Write x20 → `done`=1, `valid`=0, and x4 is not modified.
- Mid-operation reset: issue reads and writes, pulse `rst_n` low for 1 ns between edges → all outputs 0 immediately; a read of x5 after reset → 0, `valid`=1.
